// File: rtl/dec_num_entry.sv
// dec_num_entry: accumulates BCD digits into a signed 8-bit value with sign toggle, clear and sticky overflow.
module dec_num_entry #(
  parameter int MAXDIG = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       neg_key,
  input  logic       clear,
  output logic [7:0] value,
  output logic       valid,
  output logic       ovf,
  output logic [1:0] ndigits,
  output logic       bad_digit
);
  typedef enum logic [1:0] {EMPTY, ENTRY, FULL, OVF} state_t;
  state_t state, state_n;
  logic [7:0] mag, mag_n;
  logic neg, neg_n;
  logic [1:0] nd_n, nd_inc;
  logic bad_n;
  logic [11:0] prod;
  logic [11:0] lim;
  always_comb begin
    prod = 12'(mag) * 12'd10 + 12'(digit);
    lim = neg ? 12'd128 : 12'd127;
    nd_inc = ndigits + 2'd1;
    state_n = state;
    mag_n = mag;
    neg_n = neg;
    nd_n = ndigits;
    bad_n = 1'b0;
    if (clear) begin
      state_n = EMPTY;
      mag_n = '0;
      neg_n = 1'b0;
      nd_n = '0;
    end else if (enter) begin
      if (state == EMPTY || state == ENTRY) begin
        if (digit > 4'd9) bad_n = 1'b1;
        else if (prod > lim) state_n = OVF;
        else begin
          mag_n = prod[7:0];
          nd_n = nd_inc;
          state_n = (int'(nd_inc) >= MAXDIG) ? FULL : ENTRY;
        end
      end
    end else if (neg_key && state != OVF) begin
      neg_n = ~neg;
      if (neg && mag == 8'd128) state_n = OVF;
    end
  end
  // value is frozen on entry to OVF so it keeps the last in-range number
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      mag <= '0;
      neg <= 1'b0;
      ndigits <= '0;
      value <= '0;
      valid <= 1'b0;
      ovf <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      state <= state_n;
      mag <= mag_n;
      neg <= neg_n;
      ndigits <= nd_n;
      value <= (state_n == OVF) ? value : (neg_n ? ~mag_n + 8'd1 : mag_n);
      valid <= (state_n == ENTRY) || (state_n == FULL);
      ovf <= state_n == OVF;
      bad_digit <= bad_n;
    end
  end
endmodule

// File: tb/tb_dec_num_entry.sv
// tb_dec_num_entry: directed and random pulses against an integer model of decimal entry.
module tb_dec_num_entry;
  localparam int MAXDIG = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] digit = '0;
  logic enter = 1'b0, neg_key = 1'b0, clear = 1'b0;
  logic [7:0] value;
  logic valid, ovf, bad_digit;
  logic [1:0] ndigits;
  int total = 0, bad = 0;
  int m_mag = 0, m_cnt = 0, m_val = 0;
  bit m_neg = 0, m_ovf = 0, m_bad = 0;

  dec_num_entry #(.MAXDIG(MAXDIG)) dut (
    .clk(clk), .reset(reset), .digit(digit), .enter(enter), .neg_key(neg_key),
    .clear(clear), .value(value), .valid(valid), .ovf(ovf), .ndigits(ndigits),
    .bad_digit(bad_digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit c, input bit e, input int d, input bit n);
    int nv;
    m_bad = 0;
    if (r || c) begin
      m_mag = 0; m_cnt = 0; m_neg = 0; m_ovf = 0; m_val = 0;
    end else if (e) begin
      if (!m_ovf && m_cnt < MAXDIG) begin
        if (d > 9) m_bad = 1;
        else begin
          nv = m_mag * 10 + d;
          if (nv > (m_neg ? 128 : 127)) m_ovf = 1;
          else begin
            m_mag = nv;
            m_cnt++;
          end
        end
      end
    end else if (n && !m_ovf) begin
      m_neg = !m_neg;
      if (!m_neg && m_mag == 128) m_ovf = 1;
    end
    if (!m_ovf) m_val = m_neg ? -m_mag : m_mag;
  endtask

  task automatic step(input string tag, input bit r, input bit c, input bit e, input int d, input bit n);
    logic [7:0] ev;
    @(negedge clk);
    reset = r; clear = c; enter = e; digit = 4'(d); neg_key = n;
    @(posedge clk);
    #1;
    model(r, c, e, d, n);
    ev = m_val[7:0];
    chk({tag, ".value"}, value, ev);
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, m_cnt > 0 && !m_ovf});
    chk({tag, ".ovf"}, {7'd0, ovf}, {7'd0, m_ovf});
    chk({tag, ".ndigits"}, {6'd0, ndigits}, 8'(m_cnt));
    chk({tag, ".bad_digit"}, {7'd0, bad_digit}, {7'd0, m_bad});
  endtask

  task automatic dig(input string tag, input int d);
    step(tag, 0, 0, 1, d, 0);
  endtask

  initial begin
    step("reset", 1, 0, 0, 0, 0);
    chk("reset.value0", value, 8'h00);
    dig("r28a", 1); dig("r28b", 2); dig("r28c", 7);
    chk("r28.val127", value, 8'h7F);
    chk("r28.nd3", {6'd0, ndigits}, 8'd3);
    dig("r28d", 4);
    chk("r28.ignored", value, 8'h7F);
    step("clr1", 0, 1, 0, 0, 0);
    step("r29neg", 0, 0, 0, 0, 1);
    dig("r29a", 1); dig("r29b", 2); dig("r29c", 8);
    chk("r29.m128", value, 8'h80);
    step("r29tog", 0, 0, 0, 0, 1);
    chk("r29.ovf", {7'd0, ovf}, 8'd1);
    chk("r29.hold", value, 8'h80);
    step("r29negovf", 0, 0, 0, 0, 1);
    step("clr2", 0, 1, 0, 0, 0);
    dig("r30a", 2); dig("r30b", 5); dig("r30c", 6);
    chk("r30.val25", value, 8'd25);
    chk("r30.valid0", {7'd0, valid}, 8'd0);
    step("r30clr", 0, 1, 0, 0, 0);
    chk("r30.zero", value, 8'd0);
    dig("r31a", 3);
    dig("r31bad", 10);
    chk("r31.pulse", {7'd0, bad_digit}, 8'd1);
    step("r31idle", 0, 0, 0, 0, 0);
    chk("r31.pulse_end", {7'd0, bad_digit}, 8'd0);
    step("r31clren", 0, 1, 1, 4, 1);
    dig("r32a", 4); dig("r32b", 2);
    step("r32rst", 1, 1, 1, 3, 1);
    dig("r32c", 5);
    chk("r32.val5", value, 8'd5);
    dig("lz", 0); dig("lz2", 0);
    step("clr3", 0, 1, 0, 0, 0);
    dig("lz3", 0); dig("lz4", 0); dig("lz5", 7);
    chk("lz.val7", value, 8'd7);
    chk("lz.nd3", {6'd0, ndigits}, 8'd3);
    for (int i = 0; i < 600; i++) begin
      int p;
      p = $urandom_range(0, 99);
      step("rand", p < 2, p >= 2 && p < 10, p >= 10 && p < 60,
           ($urandom_range(0, 9) < 8) ? $urandom_range(0, 9) : $urandom_range(10, 15),
           ($urandom_range(0, 99) < 20));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
